// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one ALU between two requesters, with
//               multiply hold-off and result routing back to the issuer.
//               Optional macro ALU_ARB_LOCK_EN enables req 0 exclusive lock.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_r0_stb,
    input  logic [3:0]  i_r0_op,
    input  logic [31:0] i_r0_a,
    input  logic [31:0] i_r0_b,
    output logic        o_r0_stall,
    output logic        o_r0_valid,
    output logic [31:0] o_r0_c,
    output logic [3:0]  o_r0_f,
    input  logic        i_r1_stb,
    input  logic [3:0]  i_r1_op,
    input  logic [31:0] i_r1_a,
    input  logic [31:0] i_r1_b,
    output logic        o_r1_stall,
    output logic        o_r1_valid,
    output logic [31:0] o_r1_c,
    output logic [3:0]  o_r1_f,
    input  logic        i_r0_lock,
    output logic        o_alu_ce,
    output logic        o_alu_valid,
    output logic [3:0]  o_alu_op,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    input  logic [31:0] i_alu_c,
    input  logic [3:0]  i_alu_f,
    input  logic        i_alu_valid,
    input  logic        i_alu_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MPY  = 1'b1;

    logic [0:0] r_state;
    logic       r_pending;
    logic       r_owner;
    logic       r_rr_last;

    logic       w_r1_req;
    logic       w_can_issue;
    logic       w_grant;
    logic       w_issue;
    logic       w_sel_r1;
    logic       w_is_mpy;

`ifdef ALU_ARB_LOCK_EN
    assign w_r1_req = i_r1_stb & ~i_r0_lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = i_r0_lock;
    assign w_r1_req      = i_r1_stb;
`endif

    assign w_can_issue = ~i_rst & (r_state == S_IDLE) & ~i_alu_busy;
    // With only one request present the grant follows it; a tie goes to !rr_last.
    assign w_grant     = (i_r0_stb & w_r1_req) ? ~r_rr_last : ~i_r0_stb;
    assign w_issue     = w_can_issue & (i_r0_stb | w_r1_req);
    assign w_sel_r1    = w_issue & w_grant;

    assign o_alu_ce    = w_issue;
    assign o_alu_valid = w_issue;
    assign o_alu_op    = w_sel_r1 ? i_r1_op : i_r0_op;
    assign o_alu_a     = w_sel_r1 ? i_r1_a  : i_r0_a;
    assign o_alu_b     = w_sel_r1 ? i_r1_b  : i_r0_b;

    assign w_is_mpy    = (o_alu_op == 4'h8) | (o_alu_op == 4'hA) | (o_alu_op == 4'hB);

    assign o_r0_stall  = i_r0_stb & ~(w_issue & ~w_grant);
    assign o_r1_stall  = i_r1_stb & ~w_sel_r1;

    // Routing uses the pre-edge owner, so a result and a new grant may coincide.
    assign o_r0_valid  = ~i_rst & i_alu_valid & r_pending & ~r_owner;
    assign o_r1_valid  = ~i_rst & i_alu_valid & r_pending &  r_owner;
    assign o_r0_c      = i_alu_c;
    assign o_r0_f      = i_alu_f;
    assign o_r1_c      = i_alu_c;
    assign o_r1_f      = i_alu_f;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_owner   <= 1'b0;
            r_rr_last <= 1'b1;
        end else begin
            if (w_issue) begin
                r_rr_last <= w_grant;
                r_owner   <= w_grant;
                r_pending <= 1'b1;
            end else if (i_alu_valid) begin
                r_pending <= 1'b0;
            end
            case (r_state)
                S_IDLE: if (w_issue && w_is_mpy) r_state <= S_MPY;
                S_MPY:  if (i_alu_valid)         r_state <= S_IDLE;
                default:                         r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural ALU (1-cycle ops, 4-cycle multiply).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_stb, r1_stb, r0_lock;
    logic [3:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_stall, r0_valid, r1_stall, r1_valid;
    logic [31:0] r0_c, r1_c;
    logic [3:0]  r0_f, r1_f;
    logic        alu_ce, alu_valid_o;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_c;
    logic [3:0]  alu_f;
    logic        alu_valid, alu_busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_arbiter u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_stb(r0_stb), .i_r0_op(r0_op), .i_r0_a(r0_a), .i_r0_b(r0_b),
        .o_r0_stall(r0_stall), .o_r0_valid(r0_valid), .o_r0_c(r0_c), .o_r0_f(r0_f),
        .i_r1_stb(r1_stb), .i_r1_op(r1_op), .i_r1_a(r1_a), .i_r1_b(r1_b),
        .o_r1_stall(r1_stall), .o_r1_valid(r1_valid), .o_r1_c(r1_c), .o_r1_f(r1_f),
        .i_r0_lock(r0_lock),
        .o_alu_ce(alu_ce), .o_alu_valid(alu_valid_o), .o_alu_op(alu_op),
        .o_alu_a(alu_a), .o_alu_b(alu_b),
        .i_alu_c(alu_c), .i_alu_f(alu_f), .i_alu_valid(alu_valid), .i_alu_busy(alu_busy)
    );

    // Behavioural ALU; the multiply deliberately ignores reset so a stray
    // result can appear after an abandoned multiply.
    int          mpy_cnt = 0;
    logic [31:0] mpy_res = '0;
    logic [31:0] res;
    initial begin
        alu_valid = 1'b0;
        alu_c     = '0;
        alu_f     = '0;
    end
    assign alu_busy = (mpy_cnt != 0);
    always @(posedge clk) begin
        alu_valid <= 1'b0;
        if (mpy_cnt == 1) begin
            alu_valid <= 1'b1;
            alu_c     <= mpy_res;
            alu_f     <= {1'b0, mpy_res[31], 1'b0, (mpy_res == 0)};
        end
        if (mpy_cnt != 0) mpy_cnt <= mpy_cnt - 1;
        if (alu_ce) begin
            if (alu_op == 4'h8 || alu_op == 4'hA || alu_op == 4'hB) begin
                mpy_cnt <= 3;
                mpy_res <= alu_a * alu_b;
            end else begin
                case (alu_op)
                    4'h2:    res = alu_a + alu_b;
                    4'h3:    res = alu_a | alu_b;
                    default: res = alu_a ^ alu_b;
                endcase
                alu_valid <= 1'b1;
                alu_c     <= res;
                alu_f     <= {1'b0, res[31], 1'b0, (res == 0)};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_stb = 0; r1_stb = 0; r0_lock = 0;
        r0_op = 0; r1_op = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        next(); next();
        rst = 0;
        next();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        next();
        // Reset behaviour: stall mirrors stb, nothing issued or returned.
        r0_stb = 1; r1_stb = 1; r0_op = 4'h2;
        settle();
        check("rst_ce", alu_ce, 0);
        check("rst_stall0", r0_stall, 1);
        check("rst_stall1", r1_stall, 1);
        check("rst_valid", {r0_valid, r1_valid}, 0);
        next();
        do_reset();

        // 1: single ADD from r0
        r0_stb = 1; r0_op = 4'h2; r0_a = 5; r0_b = 7;
        settle();
        check("t1_ce", alu_ce, 1);
        check("t1_stall0", r0_stall, 0);
        check("t1_alu_a", alu_a, 5);
        next();
        r0_stb = 0;
        settle();
        check("t1_valid0", r0_valid, 1);
        check("t1_c", r0_c, 12);
        check("t1_f", r0_f, 0);
        check("t1_valid1", r1_valid, 0);
        next();

        // 2: both requesters OR, alternating grants from reset
        do_reset();
        r0_stb = 1; r0_op = 4'h3; r0_a = 1; r0_b = 2;
        r1_stb = 1; r1_op = 4'h3; r1_a = 4; r1_b = 8;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin r0_stb = 0; r1_stb = 0; end
            settle();
            if (i < 4) begin
                check("t2_stall0", r0_stall, (i % 2));
                check("t2_stall1", r1_stall, ((i + 1) % 2));
            end
            if (i > 0) begin
                check("t2_valid0", r0_valid, (i % 2));
                check("t2_valid1", r1_valid, ((i + 1) % 2));
                check("t2_c", r0_valid ? r0_c : r1_c, (i % 2) ? 32'd3 : 32'd12);
            end
            next();
        end

        // 3: r1 multiply holds off a waiting r0
        r1_stb = 1; r1_op = 4'h8; r1_a = 3; r1_b = 4;
        settle();
        check("t3_ce", alu_ce, 1);
        check("t3_stall1", r1_stall, 0);
        next();
        r1_stb = 0; r0_stb = 1; r0_op = 4'h2; r0_a = 1; r0_b = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_hold_stall0", r0_stall, 1);
            check("t3_hold_valid1", r1_valid, 0);
            next();
        end
        settle();
        check("t3_mpy_valid1", r1_valid, 1);
        check("t3_mpy_c", r1_c, 12);
        check("t3_mpy_stall0", r0_stall, 1);
        check("t3_mpy_valid0", r0_valid, 0);
        next();
        settle();
        check("t3_after_ce", alu_ce, 1);
        check("t3_after_stall0", r0_stall, 0);
        next();
        r0_stb = 0;
        settle();
        check("t3_add_valid0", r0_valid, 1);
        check("t3_add_c", r0_c, 2);
        next();

        // 4: reset abandons a multiply in flight
        r0_stb = 1; r0_op = 4'h8; r0_a = 3; r0_b = 4;
        settle();
        check("t4_ce", alu_ce, 1);
        next();
        idle_inputs();
        rst = 1;
        settle();
        check("t4_rst_ce", alu_ce, 0);
        next();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t4_no_valid", {r0_valid, r1_valid}, 0);
            next();
        end
        r0_stb = 1; r0_op = 4'h2; r0_a = 5; r0_b = 7;
        settle();
        check("t4_add_ce", alu_ce, 1);
        next();
        r0_stb = 0;
        settle();
        check("t4_add_valid0", r0_valid, 1);
        check("t4_add_c", r0_c, 12);
        next();

        // 5: back-to-back r0 then r1
        do_reset();
        r0_stb = 1; r0_op = 4'h2; r0_a = 10; r0_b = 20;
        settle();
        check("t5_ce0", alu_ce, 1);
        next();
        r0_stb = 0; r1_stb = 1; r1_op = 4'h2; r1_a = 1; r1_b = 2;
        settle();
        check("t5_valid0", r0_valid, 1);
        check("t5_c0", r0_c, 30);
        check("t5_ce1", alu_ce, 1);
        check("t5_stall1", r1_stall, 0);
        check("t5_alu_a", alu_a, 1);
        next();
        r1_stb = 0;
        settle();
        check("t5_valid1", r1_valid, 1);
        check("t5_c1", r1_c, 3);
        check("t5_valid0_off", r0_valid, 0);
        next();

        // 6: lock behaviour (alternation when lock support is not built in)
        do_reset();
        r0_lock = 1;
        r0_stb = 1; r0_op = 4'h3; r0_a = 1; r0_b = 0;
        r1_stb = 1; r1_op = 4'h3; r1_a = 2; r1_b = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
`ifdef ALU_ARB_LOCK_EN
            check("t6_lock_stall1", r1_stall, 1);
            check("t6_lock_stall0", r0_stall, 0);
`else
            check("t6_rr_stall1", r1_stall, ((i + 1) % 2));
            check("t6_rr_stall0", r0_stall, (i % 2));
`endif
            next();
        end
        r0_lock = 0;
        settle();
        check("t6_unlock_stall1", r1_stall, 0);
        check("t6_unlock_stall0", r0_stall, 1);
        next();
        idle_inputs();
        next(); next();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
